// File: rtl/pulse_stretch_tx.sv
// Rising-edge to fixed-width pulse generator: HIGH_CNT cycles high, then at least LOW_CNT cycles low.
// Define PULSE_STRETCH_TX_QUEUE_EN to queue events that arrive mid-pulse instead of dropping them.
module pulse_stretch_tx #(
    parameter int HIGH_CNT = 8,
    parameter int LOW_CNT  = 8,
    parameter int PEND_MAX = 3,
    parameter int CNT_W    = $clog2(((HIGH_CNT > LOW_CNT) ? HIGH_CNT : LOW_CNT) + 1),
    parameter int PEND_W   = $clog2(PEND_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_data,
    output logic              o_data,
    output logic              o_busy,
    output logic              o_drop,
    output logic [PEND_W-1:0] o_pend
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             prev_reg;
    logic             data_reg, busy_reg, drop_reg;
    logic             drop_next;
    logic             event_w;
    logic             pend_avail;
    logic             take_pend;
    logic             extra_event;

    assign event_w = i_data & ~prev_reg;

`ifdef PULSE_STRETCH_TX_QUEUE_EN
    logic [PEND_W-1:0] pend_reg, pend_next;
    logic              pend_full;

    assign pend_avail = (pend_reg != '0);
    assign pend_full  = (pend_reg >= PEND_W'(PEND_MAX));

    // Room is judged on the pre-update count, so a full queue drops even while launching.
    always_comb begin
        pend_next = pend_reg;
        drop_next = 1'b0;
        if (extra_event && !pend_full) begin
            pend_next = pend_next + 1'b1;
        end
        if (extra_event && pend_full) begin
            drop_next = 1'b1;
        end
        if (take_pend) begin
            pend_next = pend_next - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    assign o_pend = pend_reg;
`else
    assign pend_avail = 1'b0;
    assign drop_next  = extra_event;
    assign o_pend     = '0;
`endif

    // An event is consumed directly only when it launches a pulse from an empty queue.
    assign extra_event = event_w && ((state_reg != IDLE) || pend_avail);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        take_pend  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (event_w || pend_avail) begin
                    state_next = HIGH;
                    cnt_next   = CNT_W'(HIGH_CNT - 1);
                    take_pend  = pend_avail;
                end
            end
            HIGH: begin
                if (cnt_reg == '0) begin
                    state_next = GAP;
                    cnt_next   = CNT_W'(LOW_CNT - 1);
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            prev_reg  <= 1'b1;
            data_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            prev_reg  <= i_data;
            data_reg  <= (state_next == HIGH);
            busy_reg  <= (state_next != IDLE);
            drop_reg  <= drop_next;
        end
    end

    assign o_data = data_reg;
    assign o_busy = busy_reg;
    assign o_drop = drop_reg;

endmodule

// File: doc/pulse_stretch_tx.md
# pulse_stretch_tx

Output-side counterpart to the input debounce/synchronizer path. It converts rising edges on an internal, already-synchronous level into clean, width-guaranteed pulses for slow external consumers (LEDs, opto-isolators, handshake lines to slow logic). Every output pulse is high for exactly `HIGH_CNT` cycles and is followed by at least `LOW_CNT` low cycles, so the far end's debouncer always sees a stable level. Events that arrive while a pulse is in flight are queued or dropped, depending on build configuration.

## Interface
Parameters:
- `HIGH_CNT`, default 8: output high time in clk cycles, ≥1.
- `LOW_CNT`, default 8: minimum low gap between pulses in clk cycles, ≥1.
- `PEND_MAX`, default 3: maximum queued events, ≥1. Used only with the queue feature.
- `CNT_W`, default `$clog2(max(HIGH_CNT,LOW_CNT)+1)`: phase counter width, derived.
- `PEND_W`, default `$clog2(PEND_MAX+1)`: pending-count width, derived.

Ports:
- `clk`, input, 1: single clock. Everything is on posedge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `i_data`, input, 1: synchronous level. Each 0→1 transition is one event.
- `o_data`, output, 1: stretched pulse output, registered.
- `o_busy`, output, 1: high while the FSM is in HIGH or GAP.
- `o_drop`, output, 1: one-cycle strobe, high when an event was discarded.
- `o_pend`, output, `PEND_W`: number of queued events. Reads 0 when the queue feature is compiled out.

## Operation
- The edge detector registers `i_data` into `prev`. An event is `i_data & ~prev`.
  - `prev` resets to 1, so `i_data` held high through reset release produces no event.
- FSM states: IDLE, HIGH, GAP.
- IDLE:
  - `o_data`=0.
  - Event, or `pend`>0 → HIGH, counter=`HIGH_CNT`-1.
  - If entry was from `pend`, `pend` decrements.
- HIGH:
  - `o_data`=1; counter decrements each cycle.
  - Counter=0 → GAP, counter=`LOW_CNT`-1.
- GAP:
  - `o_data`=0; counter decrements each cycle.
  - Counter=0 → IDLE.
- Events seen in HIGH or GAP:
  - With the queue: `pend`++ if `pend`<`PEND_MAX`; otherwise dropped and `o_drop` pulses.
  - Without the queue: always dropped and `o_drop` pulses.
- Same-cycle increment and decrement of `pend`: net unchanged, no drop.
- Event in IDLE with `pend`>0: the event is queued (or dropped at `PEND_MAX`) and the oldest pending event launches. Net effect: `pend` unchanged unless it was full, in which case the event is dropped.
- Reset values: `o_data`=0, `o_busy`=0, `o_drop`=0, `o_pend`=0, state=IDLE, counter=0, `prev`=1.
- Reset asserted mid-pulse: `o_data` falls asynchronously and the queue is cleared. No partial pulse resumes afterwards.

## Timing
- Latency: event sampled at posedge N → `o_data` high after posedge N+1.
- `o_data` stays high for exactly `HIGH_CNT` cycles, then low for exactly `LOW_CNT` cycles before the FSM can accept the next launch.
- Back-to-back queued pulses have a period of `HIGH_CNT`+`LOW_CNT`+1 cycles, including the one IDLE cycle.
- `o_busy` is registered and aligned with the state: high from N+1 through the last GAP cycle.
- `o_drop` is high in cycle N+1 for a drop detected at posedge N.
- No combinational path from `i_data` to any output.

## Configuration
- Macro: `PULSE_STRETCH_TX_QUEUE_EN`.
- Defined: the `pend` counter is built, events during HIGH/GAP are queued up to `PEND_MAX`, and `o_pend` reflects the count.
- Undefined:
  - No `pend` register; `o_pend` is tied to 0.
  - Every event arriving in HIGH or GAP is dropped with an `o_drop` strobe.
  - An IDLE-only event launches normally.

## Test plan
- Reset: hold `rst_n`=0 for 5 cycles with `i_data`=1, then release and keep `i_data`=1. Required: `o_data`, `o_busy`, `o_drop` and `o_pend` stay 0 (no edge).
- Single pulse with defaults: a 0→1 event at cycle N. Required: `o_data`=1 for cycles N+1..N+8, 0 for N+9..N+16, and `o_busy` deasserts after N+16.
- Queue with macro on, `PEND_MAX`=3: 5 events spaced 2 cycles apart starting at N. Required:
  - First event launches.
  - `o_pend` reaches 3.
  - Fifth event causes one `o_drop`.
  - Exactly 4 pulses total, each 8 high / ≥8 low.
- Macro off: event at N, then a second event at N+3. Required: `o_drop`=1 at N+4, one pulse only, `o_pend`=0 throughout.
- Boundary, macro on: event in the last GAP cycle, plus a simultaneous launch from `pend`=1 with an event in IDLE. Required: `pend` net unchanged, no drop, next pulse starts the cycle after IDLE.
- Reset mid-pulse: assert `rst_n` at HIGH cycle 4 with `pend`=2. Required: `o_data`=0 immediately, `o_pend`=0, and no pulse after release until a new edge.
